// File: rtl/div_seq.sv
// Sequential signed restoring divider for MIPS DIV: quotient on lo_out, remainder on hi_out.
// Fixed latency of WIDTH+1 clocks from the start-accept edge to the done pulse.
module div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] rem, rem_next;
    logic [WIDTH-1:0] quo, quo_next;
    logic [WIDTH-1:0] dvsr, dvsr_next;
    logic [WIDTH-1:0] lo_next, hi_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             sign_q, sign_q_next;
    logic             sign_r, sign_r_next;
    logic             busy_next, done_next, div_zero_next;
    logic [WIDTH-1:0] rem_shift, rem_sub;
    logic             fits;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign rem_shift = {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign rem_sub   = rem_shift - dvsr;
    assign fits      = (rem_shift >= dvsr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        rem_next      = rem;
        quo_next      = quo;
        dvsr_next     = dvsr;
        cnt_next      = cnt;
        sign_q_next   = sign_q;
        sign_r_next   = sign_r;
        lo_next       = lo_out;
        hi_next       = hi_out;
        busy_next     = busy;
        done_next     = 1'b0;
        div_zero_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        div_zero_next = 1'b1;
                    end else begin
                        // Quotient register is preloaded with |dividend| and shifted out MSB first.
                        quo_next    = dividend[WIDTH-1] ? -dividend : dividend;
                        dvsr_next   = divisor[WIDTH-1] ? -divisor : divisor;
                        rem_next    = '0;
                        cnt_next    = CNT_W'(WIDTH);
                        sign_q_next = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r_next = dividend[WIDTH-1];
                        busy_next   = 1'b1;
                        state_next  = RUN;
                    end
                end
            end
            RUN: begin
                rem_next = fits ? rem_sub : rem_shift;
                quo_next = {quo[WIDTH-2:0], fits};
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_next = SIGN;
            end
            SIGN: begin
                lo_next    = sign_q ? -quo : quo;
                hi_next    = sign_r ? -rem : rem;
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            lo_out   <= '0;
            hi_out   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            rem      <= rem_next;
            quo      <= quo_next;
            dvsr     <= dvsr_next;
            cnt      <= cnt_next;
            sign_q   <= sign_q_next;
            sign_r   <= sign_r_next;
            lo_out   <= lo_next;
            hi_out   <= hi_next;
            busy     <= busy_next;
            done     <= done_next;
            div_zero <= div_zero_next;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed MIPS DIV cases plus random operands
// compared against a 64-bit arithmetic reference.
module tb_div_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] lo_out;
    logic [31:0] hi_out;
    logic        busy;
    logic        done;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .lo_out   (lo_out),
        .hi_out   (hi_out),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Truncating signed division in 64 bits; the result wraps back to 32 bits.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = 32'(sa / sb);
        r  = 32'(sa % sb);
    endfunction

    // Issue one operation and wait for done; lat = edges after the accept edge.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_bad);
        int k;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        k        = 0;
        lat      = -1;
        busy_bad = 0;
        while (k <= 50 && lat < 0) begin
            if (done) begin
                lat = k;
            end else begin
                if (!busy) busy_bad++;
                tick();
                k++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++; if (lo_out !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo_out); end
        checks++; if (hi_out !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_divzero got=%b exp=0", div_zero); end
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_directed();
        logic [31:0] ta [7];
        logic [31:0] tb [7];
        logic [31:0] tq [7];
        logic [31:0] tr [7];
        int lat, bb;
        ta = '{32'd7, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'h80000000, 32'd0, 32'hFFFFFFFF};
        tb = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF};
        tq = '{32'd3, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd3, 32'h80000000, 32'd0, 32'd1};
        tr = '{32'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 7; i++) begin
            do_op(ta[i], tb[i], lat, bb);
            checks++; if (lat != 33) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=33", i, lat); end
            checks++; if (bb != 0) begin failures++; $display("FAIL dir%0d_busy low_cycles=%0d exp=0", i, bb); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dir%0d_busy_at_done got=%b exp=0", i, busy); end
            checks++; if (lo_out !== tq[i]) begin failures++; $display("FAIL dir%0d_lo got=%h exp=%h", i, lo_out, tq[i]); end
            checks++; if (hi_out !== tr[i]) begin failures++; $display("FAIL dir%0d_hi got=%h exp=%h", i, hi_out, tr[i]); end
            tick();
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_div_zero();
        int lat, bb, ndone, nbusy;
        do_op(32'd7, 32'd2, lat, bb);
        tick();
        dividend = 32'd5;
        divisor  = 32'd0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        checks++; if (div_zero !== 1'b1) begin failures++; $display("FAIL dz_pulse got=%b exp=1", div_zero); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dz_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL dz_done_same got=%b exp=0", done); end
        tick();
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL dz_pulse_width got=%b exp=0", div_zero); end
        ndone = 0;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            if (busy) nbusy++;
            tick();
        end
        checks++; if (ndone != 0) begin failures++; $display("FAIL dz_no_done got=%0d exp=0", ndone); end
        checks++; if (nbusy != 0) begin failures++; $display("FAIL dz_no_busy got=%0d exp=0", nbusy); end
        checks++; if (lo_out !== 32'd3) begin failures++; $display("FAIL dz_lo_kept got=%h exp=3", lo_out); end
        checks++; if (hi_out !== 32'd1) begin failures++; $display("FAIL dz_hi_kept got=%h exp=1", hi_out); end
    endtask

    task automatic test_back_to_back();
        int k, lat, ndone, bb;
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        k        = 0;
        lat      = -1;
        ndone    = 0;
        while (k <= 50 && lat < 0) begin
            if (done) begin
                lat = k;
            end else begin
                start = (k == 9);
                if (k == 9) begin
                    dividend = 32'd9;
                    divisor  = 32'd3;
                end
                tick();
                k++;
            end
        end
        start = 1'b0;
        checks++; if (lat != 33) begin failures++; $display("FAIL busy_start_latency got=%0d exp=33", lat); end
        checks++; if (lo_out !== 32'd14) begin failures++; $display("FAIL busy_start_lo got=%h exp=e", lo_out); end
        checks++; if (hi_out !== 32'd2) begin failures++; $display("FAIL busy_start_hi got=%h exp=2", hi_out); end
        // Issue the next op during the done cycle.
        do_op(32'd9, 32'd3, lat, bb);
        checks++; if (lat != 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
        checks++; if (bb != 0) begin failures++; $display("FAIL b2b_busy low_cycles=%0d exp=0", bb); end
        checks++; if (lo_out !== 32'd3) begin failures++; $display("FAIL b2b_lo got=%h exp=3", lo_out); end
        checks++; if (hi_out !== 32'd0) begin failures++; $display("FAIL b2b_hi got=%h exp=0", hi_out); end
        tick();
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            tick();
        end
        checks++; if (ndone != 0) begin failures++; $display("FAIL b2b_extra_done got=%0d exp=0", ndone); end
    endtask

    task automatic test_reset_mid();
        int lat, bb, ndone;
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before got=%b exp=1", busy); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (lo_out !== 32'h0) begin failures++; $display("FAIL rst_mid_lo got=%h exp=0", lo_out); end
        checks++; if (hi_out !== 32'h0) begin failures++; $display("FAIL rst_mid_hi got=%h exp=0", hi_out); end
        tick();
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) ndone++;
            tick();
        end
        checks++; if (ndone != 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", ndone); end
        do_op(32'd10, 32'd3, lat, bb);
        checks++; if (lat != 33) begin failures++; $display("FAIL rst_after_latency got=%0d exp=33", lat); end
        checks++; if (lo_out !== 32'd3) begin failures++; $display("FAIL rst_after_lo got=%h exp=3", lo_out); end
        checks++; if (hi_out !== 32'd1) begin failures++; $display("FAIL rst_after_hi got=%h exp=1", hi_out); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] a, b, eq, er;
        int lat, bb;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) b = b >> $urandom_range(31, 20);
            if (i % 4 == 1) b = -b;
            if (i % 5 == 2) a = a >> $urandom_range(31, 8);
            if (b == 32'd0) b = 32'd1;
            model(a, b, eq, er);
            do_op(a, b, lat, bb);
            checks++; if (lat != 33) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=33", i, lat); end
            checks++; if (lo_out !== eq) begin failures++; $display("FAIL rnd%0d_lo a=%h b=%h got=%h exp=%h", i, a, b, lo_out, eq); end
            checks++; if (hi_out !== er) begin failures++; $display("FAIL rnd%0d_hi a=%h b=%h got=%h exp=%h", i, a, b, hi_out, er); end
            checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL rnd%0d_divzero got=%b exp=0", i, div_zero); end
            if (i % 2 == 0) tick();
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        test_reset();
        test_directed();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
